// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the 4-bit MAC sequencer.
package mac_pkg;
    localparam int OP_W       = 4;
    localparam int ACC_W      = 8;
    localparam int MUL_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/brent_kung_8bit.sv
// 8-bit Brent-Kung parallel-prefix adder.
module Brent_kung_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic g0c, g10, g20, g30, g40, g50, g60, g70;
    logic g32, p32, g54, p54, g76, p76, g74, p74;

    assign g = a & b;
    assign p = a ^ b;

    // Up-sweep: pairwise then quad group terms
    assign g0c = g[0] | (p[0] & cin);
    assign g10 = g[1] | (p[1] & g0c);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g30 = g32 | (p32 & g10);
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;
    assign g70 = g74 | (p74 & g30);

    // Down-sweep fills the remaining prefixes
    assign g50 = g54 | (p54 & g30);
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);
    assign g60 = g[6] | (p[6] & g50);

    assign c    = {g60, g50, g40, g30, g20, g10, g0c, cin};
    assign s    = p ^ c;
    assign cout = g70;
endmodule

// File: rtl/mac4_seq_ctrl.sv
// Shift-add MAC sequencer: one operand pair per 5 cycles through one
// shared adder, result presented after the pair flagged last.
module mac4_seq_ctrl #(
    parameter int OP_W  = mac_pkg::OP_W,
    parameter int ACC_W = mac_pkg::ACC_W,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             busy
);
    import mac_pkg::*;

    if (OP_W != 4 || ACC_W != 8) begin : g_cfg_err
        $error("mac4_seq_ctrl: OP_W must be 4 and ACC_W must be 8");
    end

    localparam logic [1:0] CNT_LAST = 2'(MUL_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        cnt;
    logic [OP_W-1:0]   a_r;
    logic [OP_W-1:0]   b_r;
    logic              last_r;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  a_ext;
    logic [ACC_W-1:0]  y;
    logic [ACC_W-1:0]  sum;
    logic              cout;

    assign a_ext = {{(ACC_W-OP_W){1'b0}}, a_r};
    assign y     = b_r[cnt] ? (a_ext << cnt) : '0;

    Brent_kung_8bit u_add (
        .a    (acc),
        .b    (y),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid)        state_nx = MUL;
            MUL:  if (cnt == CNT_LAST) state_nx = last_r ? DONE : IDLE;
            DONE: if (out_ready)       state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Saturation latches at all-ones once any carry has been seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            last_r <= 1'b0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a;
                    b_r    <= b;
                    last_r <= last;
                    cnt    <= '0;
                end
                MUL: begin
                    cnt <= cnt + 2'd1;
                    ovf <= ovf | cout;
                    if (SAT && (cout || ovf)) acc <= '1;
                    else                      acc <= sum;
                end
                DONE: if (out_ready) begin
                    acc <= '0;
                    ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign acc_out = acc;
endmodule

// File: tb/tb_mac4_seq_ctrl.sv
// Self-checking bench: wrap and saturating instances driven in lockstep,
// checked against an arithmetic sum-of-products model.
module tb_mac4_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       last = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;

    logic       in_ready0, out_valid0, ovf0, busy0;
    logic       in_ready1, out_valid1, ovf1, busy1;
    logic [7:0] acc0, acc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac4_seq_ctrl #(.SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .last(last), .out_valid(out_valid0),
        .out_ready(out_ready), .acc_out(acc0), .ovf(ovf0), .busy(busy0)
    );

    mac4_seq_ctrl #(.SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .last(last), .out_valid(out_valid1),
        .out_ready(out_ready), .acc_out(acc1), .ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a pair, wait for acceptance, then watch the four MUL cycles.
    task automatic send(input logic [3:0] ta, input logic [3:0] tb,
                        input logic tl);
        int n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(in_ready0), 32'd1);
        a = ta;
        b = tb;
        last = tl;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            else @(negedge clk);
            check("mul_in_ready", 32'(in_ready0 | in_ready1), 32'd0);
            check("mul_busy", 32'(busy0 & busy1), 32'd1);
            check("mul_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        end
    endtask

    // Expect the result on the very next cycle, hold it, then take it.
    task automatic get_result(input int total, input int hold);
        int n = 0;
        int ew = total % 256;
        int es = (total > 255) ? 255 : total;
        int eo = (total > 255) ? 1 : 0;
        @(negedge clk);
        while (!out_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            check("out_valid", 32'(out_valid0 & out_valid1), 32'd1);
            check("done_in_ready", 32'(in_ready0 | in_ready1), 32'd0);
            check("acc_wrap", 32'(acc0), 32'(ew));
            check("ovf_wrap", 32'(ovf0), 32'(eo));
            check("acc_sat", 32'(acc1), 32'(es));
            check("ovf_sat", 32'(ovf1), 32'(eo));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int nt;
        logic [3:0] ra, rb;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy0 | busy1), 32'd0);
        check("rst_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("rst_acc", 32'(acc0 | acc1), 32'd0);
        check("rst_ovf", 32'(ovf0 | ovf1), 32'd0);
        rst = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready0 & in_ready1), 32'd1);

        send(4'd3, 4'd5, 1'b1);
        get_result(15, 0);

        send(4'd15, 4'd15, 1'b0);
        send(4'd1, 4'd1, 1'b0);
        send(4'd0, 4'd9, 1'b1);
        get_result(226, 0);

        send(4'd15, 4'd15, 1'b0);
        send(4'd15, 4'd15, 1'b1);
        get_result(450, 10);

        send(4'd2, 4'd2, 1'b1);
        get_result(4, 0);

        @(negedge clk);
        a = 4'd7;
        b = 4'd7;
        last = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy0 | busy1), 32'd0);
        check("mrst_out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("mrst_acc", 32'(acc0 | acc1), 32'd0);
        check("mrst_ovf", 32'(ovf0 | ovf1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mrst_in_ready", 32'(in_ready0 & in_ready1), 32'd1);
        send(4'd7, 4'd7, 1'b1);
        get_result(49, 0);

        send(4'd1, 4'd1, 1'b0);
        a = 4'd4;
        b = 4'd3;
        last = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("hold_idle_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_mul_ready", 32'(in_ready0), 32'd0);
            check("hold_mul_busy", 32'(busy0), 32'd1);
        end
        in_valid = 1'b0;
        get_result(13, 2);

        for (int s = 0; s < 1000; s++) begin
            total = 0;
            nt = $urandom_range(1, 4);
            for (int t = 0; t < nt; t++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ra = 4'd15;
                    rb = 4'($urandom_range(12, 15));
                end else begin
                    ra = 4'($urandom);
                    rb = 4'($urandom);
                end
                send(ra, rb, t == nt - 1);
                total += int'(ra) * int'(rb);
            end
            get_result(total, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
